alarm_sequencer: RTL and testbench

Controls the alarm clock. It compares the running BCD time from the watch counter with the programmed alarm time and sequences the ringing output. It also handles snooze, stop and ring timeout. It sits between the time-keeping counter and sound_control, driving the audio enable from the arming switch and the two user buttons.

---
 rtl/alarm_sequencer_if.sv | 42 ++++
 rtl/alarm_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alarm_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if: groups the alarm sequencer's control inputs, BCD time
// buses and status outputs into one bundle.
// slave  : the sequencer itself (consumes time/buttons, drives status)
// master : the surrounding system or testbench (drives time/buttons)
interface alarm_sequencer_if;
    logic       tick_sec;
    logic       bud_en;
    logic       stop_btn;
    logic       snooze_btn;
    logic [3:0] hourdec_now;
    logic [3:0] hourone_now;
    logic [3:0] mindec_now;
    logic [3:0] minone_now;
    logic [3:0] hourdec_bud;
    logic [3:0] hourone_bud;
    logic [3:0] mindec_bud;
    logic [3:0] minone_bud;
    logic       aud_en;
    logic       bud_state_o;
    logic [1:0] state_o;
    logic [2:0] snooze_cnt_o;
    logic [3:0] snz_hourdec;
    logic [3:0] snz_hourone;
    logic [3:0] snz_mindec;
    logic [3:0] snz_minone;

    modport slave (
        input  tick_sec, bud_en, stop_btn, snooze_btn,
        input  hourdec_now, hourone_now, mindec_now, minone_now,
        input  hourdec_bud, hourone_bud, mindec_bud, minone_bud,
        output aud_en, bud_state_o, state_o, snooze_cnt_o,
        output snz_hourdec, snz_hourone, snz_mindec, snz_minone
    );

    modport master (
        output tick_sec, bud_en, stop_btn, snooze_btn,
        output hourdec_now, hourone_now, mindec_now, minone_now,
        output hourdec_bud, hourone_bud, mindec_bud, minone_bud,
        input  aud_en, bud_state_o, state_o, snooze_cnt_o,
        input  snz_hourdec, snz_hourone, snz_mindec, snz_minone
    );
endinterface

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: compares the running BCD time against the alarm time,
// sequences ringing, snooze (with BCD snooze-target arithmetic), stop and
// ring timeout. All outputs are registered.
// Optional build macro: ALARM_BEEP_EN -- when defined, aud_en alternates
// 1 s on / 1 s off while ringing instead of being held high.
module alarm_sequencer #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic                clk,
    input  logic                rst,
    alarm_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_ring_cnt;
    logic [7:0] w_ring_cnt_nxt;
    logic [2:0] r_snz_cnt;
    logic [2:0] w_snz_cnt_nxt;
    logic       w_load_snz;
    logic       r_match_a;
    logic       r_match_s;
    logic       r_aud_en;
    logic       r_bud_state;
    logic [3:0] r_snz_hourdec;
    logic [3:0] r_snz_hourone;
    logic [3:0] r_snz_mindec;
    logic [3:0] r_snz_minone;

    logic       w_match_a;
    logic       w_match_s;
    logic       w_trig_a;
    logic       w_trig_s;
    logic       w_timeout;
    logic       w_aud_nxt;

    logic [7:0] w_min_sum;
    logic [7:0] w_min_adj;
    logic       w_carry;
    logic [7:0] w_hour_sum;
    logic [7:0] w_hour_adj;

    // Literal 4-digit compares; triggers fire only on the 0->1 edge of a match
    assign w_match_a = (bus.hourdec_now == bus.hourdec_bud) && (bus.hourone_now == bus.hourone_bud) &&
                       (bus.mindec_now  == bus.mindec_bud)  && (bus.minone_now  == bus.minone_bud);
    assign w_match_s = (bus.hourdec_now == r_snz_hourdec) && (bus.hourone_now == r_snz_hourone) &&
                       (bus.mindec_now  == r_snz_mindec)  && (bus.minone_now  == r_snz_minone);
    assign w_trig_a  = w_match_a && !r_match_a;
    assign w_trig_s  = w_match_s && !r_match_s;
    assign w_timeout = (r_state == ST_RINGING) && bus.tick_sec && (r_ring_cnt == 8'(RING_SEC - 1));

    // Snooze target: now + SNOOZE_MIN minutes, carrying into hours and wrapping at 24
    assign w_min_sum  = {4'd0, bus.mindec_now} * 8'd10 + {4'd0, bus.minone_now} + 8'(SNOOZE_MIN);
    assign w_carry    = (w_min_sum >= 8'd60);
    assign w_min_adj  = w_carry ? (w_min_sum - 8'd60) : w_min_sum;
    assign w_hour_sum = {4'd0, bus.hourdec_now} * 8'd10 + {4'd0, bus.hourone_now} + {7'd0, w_carry};
    assign w_hour_adj = (w_hour_sum >= 8'd24) ? (w_hour_sum - 8'd24) : w_hour_sum;

    // Next-state logic: bud_en low > stop > timeout > snooze > match trigger
    always_comb begin
        w_next_state   = r_state;
        w_ring_cnt_nxt = r_ring_cnt;
        w_snz_cnt_nxt  = r_snz_cnt;
        w_load_snz     = 1'b0;
        if (!bus.bud_en) begin
            w_next_state  = ST_IDLE;
            w_snz_cnt_nxt = 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_trig_a) begin
                        w_next_state   = ST_RINGING;
                        w_ring_cnt_nxt = 8'd0;
                        w_snz_cnt_nxt  = 3'd0;
                    end
                end
                ST_RINGING: begin
                    if (bus.tick_sec) begin
                        w_ring_cnt_nxt = r_ring_cnt + 8'd1;
                    end
                    if (bus.stop_btn || w_timeout) begin
                        w_next_state  = ST_ARMED;
                        w_snz_cnt_nxt = 3'd0;
                    end else if (bus.snooze_btn && (r_snz_cnt < 3'(MAX_SNOOZE))) begin
                        w_next_state  = ST_SNOOZE;
                        w_snz_cnt_nxt = r_snz_cnt + 3'd1;
                        w_load_snz    = 1'b1;
                    end
                end
                ST_SNOOZE: begin
                    if (bus.stop_btn) begin
                        w_next_state  = ST_ARMED;
                        w_snz_cnt_nxt = 3'd0;
                    end else if (w_trig_s) begin
                        w_next_state   = ST_RINGING;
                        w_ring_cnt_nxt = 8'd0;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALARM_BEEP_EN
    logic r_beep;
    logic w_beep_nxt;

    // Beep phase: restarts "on" at RINGING entry, flips on every second while ringing
    always_comb begin
        w_beep_nxt = r_beep;
        if (w_next_state == ST_RINGING && r_state != ST_RINGING) begin
            w_beep_nxt = 1'b0;
        end else if (r_state == ST_RINGING && bus.tick_sec) begin
            w_beep_nxt = !r_beep;
        end
    end

    // Beep phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beep <= 1'b0;
        end else begin
            r_beep <= w_beep_nxt;
        end
    end

    assign w_aud_nxt = (w_next_state == ST_RINGING) && !w_beep_nxt;
`else
    assign w_aud_nxt = (w_next_state == ST_RINGING);
`endif

    // State, counters, match history and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ring_cnt    <= 8'd0;
            r_snz_cnt     <= 3'd0;
            r_match_a     <= 1'b0;
            r_match_s     <= 1'b0;
            r_aud_en      <= 1'b0;
            r_bud_state   <= 1'b0;
            r_snz_hourdec <= 4'd0;
            r_snz_hourone <= 4'd0;
            r_snz_mindec  <= 4'd0;
            r_snz_minone  <= 4'd0;
        end else begin
            r_state     <= w_next_state;
            r_ring_cnt  <= w_ring_cnt_nxt;
            r_snz_cnt   <= w_snz_cnt_nxt;
            r_match_a   <= w_match_a;
            r_match_s   <= w_match_s;
            r_aud_en    <= w_aud_nxt;
            r_bud_state <= (w_next_state == ST_RINGING);
            if (w_load_snz) begin
                r_snz_hourdec <= 4'(w_hour_adj / 8'd10);
                r_snz_hourone <= 4'(w_hour_adj % 8'd10);
                r_snz_mindec  <= 4'(w_min_adj / 8'd10);
                r_snz_minone  <= 4'(w_min_adj % 8'd10);
            end
        end
    end

    assign bus.aud_en       = r_aud_en;
    assign bus.bud_state_o  = r_bud_state;
    assign bus.state_o      = r_state;
    assign bus.snooze_cnt_o = r_snz_cnt;
    assign bus.snz_hourdec  = r_snz_hourdec;
    assign bus.snz_hourone  = r_snz_hourone;
    assign bus.snz_mindec   = r_snz_mindec;
    assign bus.snz_minone   = r_snz_minone;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: table-driven one-vector-per-clock checks of the
// alarm sequencer (RING_SEC=4, SNOOZE_MIN=5, MAX_SNOOZE=3), plus
// hand-written sequences for BCD wrap, carry and asynchronous reset.
module tb_alarm_sequencer;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    alarm_sequencer_if bus ();

    alarm_sequencer #(
        .RING_SEC   (4),
        .SNOOZE_MIN (5),
        .MAX_SNOOZE (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        budEn;
        logic        tick;
        logic        stop;
        logic        snooze;
        logic [15:0] now;
        logic [1:0]  expState;
        logic        expAud;
        logic [2:0]  expCnt;
        logic [15:0] expSnz;
    } vec_t;

    vec_t vecs[32];

    function automatic vec_t mk(logic budEn, logic tick, logic stop, logic snooze,
                                logic [15:0] now, logic [1:0] st, logic aud,
                                logic [2:0] cnt, logic [15:0] snz);
        vec_t v;
        v.budEn = budEn; v.tick = tick; v.stop = stop; v.snooze = snooze;
        v.now = now; v.expState = st; v.expAud = aud; v.expCnt = cnt; v.expSnz = snz;
        return v;
    endfunction

    // Compare one observed value with its expected value
    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the full visible status against expectations
    task automatic checkAll(input string tag, input logic [1:0] st, input logic aud,
                            input logic [2:0] cnt, input logic [15:0] snz);
        checkOutput({tag, " state"}, {14'd0, bus.state_o}, {14'd0, st});
        checkOutput({tag, " aud_en"}, {15'd0, bus.aud_en}, {15'd0, aud});
        checkOutput({tag, " bud_state"}, {15'd0, bus.bud_state_o}, {15'd0, (st == 2'd2)});
        checkOutput({tag, " snooze_cnt"}, {13'd0, bus.snooze_cnt_o}, {13'd0, cnt});
        checkOutput({tag, " snz"}, {bus.snz_hourdec, bus.snz_hourone, bus.snz_mindec, bus.snz_minone}, snz);
    endtask

    task automatic setNow(input logic [15:0] t);
        {bus.hourdec_now, bus.hourone_now, bus.mindec_now, bus.minone_now} = t;
    endtask

    task automatic setBud(input logic [15:0] t);
        {bus.hourdec_bud, bus.hourone_bud, bus.mindec_bud, bus.minone_bud} = t;
    endtask

    // Drive one vector for exactly one clock, then sample 1 ns after the edge
    task automatic applyStimulus(input vec_t v);
        bus.bud_en     = v.budEn;
        bus.tick_sec   = v.tick;
        bus.stop_btn   = v.stop;
        bus.snooze_btn = v.snooze;
        setNow(v.now);
        @(posedge clk);
        #1;
        bus.tick_sec   = 1'b0;
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        // Alarm 07:30: ring, stop, snooze three times, fourth ignored,
        // stop+snooze together, 4-tick timeout, bud_en drop, arming in-match
        vecs[0]  = mk(1,0,0,0,16'h0729, 2'd1,0,3'd0,16'h0000);
        vecs[1]  = mk(1,0,0,0,16'h0729, 2'd1,0,3'd0,16'h0000);
        vecs[2]  = mk(1,0,0,0,16'h0730, 2'd2,1,3'd0,16'h0000);
        vecs[3]  = mk(1,0,1,0,16'h0730, 2'd1,0,3'd0,16'h0000);
        vecs[4]  = mk(1,0,0,0,16'h0730, 2'd1,0,3'd0,16'h0000);
        vecs[5]  = mk(1,0,0,0,16'h0731, 2'd1,0,3'd0,16'h0000);
        vecs[6]  = mk(1,0,0,0,16'h0730, 2'd2,1,3'd0,16'h0000);
        vecs[7]  = mk(1,0,0,1,16'h0730, 2'd3,0,3'd1,16'h0735);
        vecs[8]  = mk(1,0,0,0,16'h0734, 2'd3,0,3'd1,16'h0735);
        vecs[9]  = mk(1,0,0,0,16'h0735, 2'd2,1,3'd1,16'h0735);
        vecs[10] = mk(1,0,0,1,16'h0735, 2'd3,0,3'd2,16'h0740);
        vecs[11] = mk(1,0,0,0,16'h0739, 2'd3,0,3'd2,16'h0740);
        vecs[12] = mk(1,0,0,0,16'h0740, 2'd2,1,3'd2,16'h0740);
        vecs[13] = mk(1,0,0,1,16'h0740, 2'd3,0,3'd3,16'h0745);
        vecs[14] = mk(1,0,0,0,16'h0744, 2'd3,0,3'd3,16'h0745);
        vecs[15] = mk(1,0,0,0,16'h0745, 2'd2,1,3'd3,16'h0745);
        vecs[16] = mk(1,0,0,1,16'h0745, 2'd2,1,3'd3,16'h0745);
        vecs[17] = mk(1,0,1,1,16'h0745, 2'd1,0,3'd0,16'h0745);
        vecs[18] = mk(1,0,0,0,16'h0729, 2'd1,0,3'd0,16'h0745);
        vecs[19] = mk(1,0,0,0,16'h0730, 2'd2,1,3'd0,16'h0745);
        vecs[20] = mk(1,1,0,0,16'h0730, 2'd2,1,3'd0,16'h0745);
        vecs[21] = mk(1,1,0,0,16'h0730, 2'd2,1,3'd0,16'h0745);
        vecs[22] = mk(1,1,0,0,16'h0730, 2'd2,1,3'd0,16'h0745);
        vecs[23] = mk(1,1,0,0,16'h0730, 2'd1,0,3'd0,16'h0745);
        vecs[24] = mk(1,0,0,0,16'h0731, 2'd1,0,3'd0,16'h0745);
        vecs[25] = mk(1,0,0,0,16'h0730, 2'd2,1,3'd0,16'h0745);
        vecs[26] = mk(0,0,0,0,16'h0730, 2'd0,0,3'd0,16'h0745);
        vecs[27] = mk(1,0,0,0,16'h0729, 2'd1,0,3'd0,16'h0745);
        vecs[28] = mk(0,0,0,0,16'h0730, 2'd0,0,3'd0,16'h0745);
        vecs[29] = mk(1,0,0,0,16'h0730, 2'd1,0,3'd0,16'h0745);
        vecs[30] = mk(1,0,0,0,16'h0730, 2'd1,0,3'd0,16'h0745);
        vecs[31] = mk(1,0,0,0,16'h0731, 2'd1,0,3'd0,16'h0745);

        rst            = 1'b1;
        bus.bud_en     = 1'b0;
        bus.tick_sec   = 1'b0;
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
        setNow(16'h0729);
        setBud(16'h0730);
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 2'd0, 1'b0, 3'd0, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            applyStimulus(vecs[i]);
            checkAll($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expAud,
                     vecs[i].expCnt, vecs[i].expSnz);
        end

        // 23:58 + 5 min wraps through midnight to 00:03
        setBud(16'h2358);
        applyStimulus(mk(1,0,0,0,16'h2357, 2'd1,0,3'd0,16'h0745));
        checkAll("wrap arm", 2'd1, 1'b0, 3'd0, 16'h0745);
        applyStimulus(mk(1,0,0,0,16'h2358, 2'd2,1,3'd0,16'h0745));
        checkAll("wrap ring", 2'd2, 1'b1, 3'd0, 16'h0745);
        applyStimulus(mk(1,0,0,1,16'h2358, 2'd3,0,3'd1,16'h0003));
        checkAll("wrap snooze", 2'd3, 1'b0, 3'd1, 16'h0003);
        applyStimulus(mk(1,0,1,0,16'h2358, 2'd1,0,3'd0,16'h0003));
        checkAll("snooze stop", 2'd1, 1'b0, 3'd0, 16'h0003);

        // 09:57 + 5 min carries into the hour tens digit: 10:02
        setBud(16'h0957);
        applyStimulus(mk(1,0,0,0,16'h0956, 2'd1,0,3'd0,16'h0003));
        applyStimulus(mk(1,0,0,0,16'h0957, 2'd2,1,3'd0,16'h0003));
        checkAll("carry ring", 2'd2, 1'b1, 3'd0, 16'h0003);
        applyStimulus(mk(1,0,0,1,16'h0957, 2'd3,0,3'd1,16'h1002));
        checkAll("carry snooze", 2'd3, 1'b0, 3'd1, 16'h1002);
        applyStimulus(mk(1,0,1,0,16'h0957, 2'd1,0,3'd0,16'h1002));
        applyStimulus(mk(1,0,0,0,16'h0956, 2'd1,0,3'd0,16'h1002));
        applyStimulus(mk(1,0,0,0,16'h0957, 2'd2,1,3'd0,16'h1002));
        checkAll("pre-reset ring", 2'd2, 1'b1, 3'd0, 16'h1002);

        // Reset mid-ring clears outputs without waiting for a clock edge
        #1;
        rst = 1'b1;
        #1;
        checkAll("async reset", 2'd0, 1'b0, 3'd0, 16'h0000);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkAll("post-reset via idle", 2'd1, 1'b0, 3'd0, 16'h0000);
        applyStimulus(mk(1,0,0,0,16'h0957, 2'd1,0,3'd0,16'h0000));
        checkAll("post-reset no ring", 2'd1, 1'b0, 3'd0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
